sw_cond: RTL and testbench
==========================

Name: sw_cond

Overview:
- Input conditioner between the board slide switches and the MMIO switch register at 0xC001.
- Synchronises each raw switch bit into clk with two flops, then debounces it.
- Publishes the stable switch vector that the memory map returns on reads of 0xC001.
- Optionally keeps sticky per-bit change flags, which software clears by write-1-to-clear, plus a summary interrupt line.

Parameters:
- WIDTH, 10, number of switch bits conditioned.
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronised input must differ from sw_o before sw_o takes the new value (10 ms at 50 MHz). Must be >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each per-bit stability counter. Derived from DEBOUNCE_CYCLES; do not override.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  reset, synchronous, active-high
- sw_i  input  WIDTH  raw asynchronous switch pins (SW)
- sw_o  output  WIDTH  debounced, synchronised switch value
- edge_o  output  WIDTH  one-cycle pulse per bit when the matching sw_o bit toggles
- clr_i  input  WIDTH  write-1-to-clear strobe for chg_o; the memory map drives this on a store to 0xC001 with the store data
- chg_o  output  WIDTH  sticky change flags
- irq_o  output  1  OR of all chg_o bits

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high and is sampled only on the rising edge of clk.
- Reset values: while rst is high at a clk edge, the following are all cleared to 0:
  - both synchroniser stages;
  - all counters;
  - sw_o, edge_o, chg_o, irq_o.
- Synchroniser, per bit: s1 <= sw_i; s2 <= s1. s2 is the only consumer of sw_i. No combinational path exists from sw_i to any output.
- Stability counter, per bit:
  - If s2 == sw_o, cnt <= 0.
  - If s2 != sw_o and cnt < DEBOUNCE_CYCLES-1, cnt <= cnt+1.
  - If s2 != sw_o and cnt == DEBOUNCE_CYCLES-1:
    - sw_o <= s2 and cnt <= 0;
    - edge_o is high for exactly the following cycle.
- Debounce rule: sw_o changes only after DEBOUNCE_CYCLES consecutive mismatching cycles. Any single cycle of agreement restarts the count from 0.
- Latency: a clean step on sw_i appears on sw_o after exactly 2 + DEBOUNCE_CYCLES clk edges. edge_o rises on that same edge.
- No saturation: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Independence: bits are fully independent. Several bits may update, pulse and set flags in the same cycle.
- Bouncing input: if the input toggles faster than DEBOUNCE_CYCLES, sw_o holds its last stable value indefinitely.
- edge_o is a registered output. It is zero in every cycle in which the corresponding sw_o bit did not toggle.
- Reset mid-count: all progress is discarded. After rst deasserts, a held-high switch takes 2 + DEBOUNCE_CYCLES cycles to appear on sw_o and then produces an edge_o pulse. This is intended: software sees a power-on change.

Optional Feature:
- Macro: SW_COND_STICKY_EN.
- Defined:
  - chg_o[i] is set on the cycle edge_o[i] is high and held until cleared.
  - clr_i[i] high for one cycle clears chg_o[i] at the next edge.
  - If set and clear coincide on the same bit, set wins and chg_o[i] stays 1.
  - irq_o is registered and follows the OR of chg_o with one cycle of delay.
- Undefined:
  - chg_o and irq_o are tied to 0;
  - clr_i is ignored;
  - no flag storage is synthesised.

Test Plan (DEBOUNCE_CYCLES=8, WIDTH=10):
1. Reset: hold rst high for 3 cycles with sw_i=10'h3FF, then release -> sw_o=0, edge_o=0, chg_o=0 during reset. sw_o becomes 10'h3FF exactly 10 edges after release. edge_o=10'h3FF for 1 cycle.
2. Clean step: sw_i[0] steps 0->1 and holds -> sw_o[0]=1 exactly 10 edges later. edge_o[0] pulses for 1 cycle. All other sw_o bits are unchanged.
3. Glitch rejection: sw_i[3] goes high for 7 cycles, then low -> sw_o[3] stays 0 and edge_o[3] never pulses. Repeat with high for 8 cycles -> sw_o[3]=1.
4. Bounce: sw_i[5] toggles every 4 cycles for 100 cycles, then holds at 1 -> sw_o[5]=0 throughout the bouncing, then 1 exactly 10 edges after the last toggle.
5. Sticky flags (macro defined): step sw_i[2] -> chg_o=10'h004 and irq_o=1 on the next cycle. Pulse clr_i=10'h004 -> chg_o=0 and irq_o=0. Assert clr_i[2] in the same cycle as a new edge_o[2] -> chg_o[2] stays 1.
6. Reset mid-count: sw_i[7] high, assert rst 5 cycles into the count -> sw_o[7]=0. It updates 10 edges after rst deasserts, not earlier.

Source files
------------

// File: rtl/sw_cond.sv
// Slide-switch conditioner: two-flop synchroniser plus per-bit debounce feeding the 0xC001 switch register.
// Define SW_COND_STICKY_EN to add sticky write-1-to-clear change flags and a summary interrupt.
module sw_cond #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] edge_o,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] chg_o,
    output logic             irq_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0]            s1_r;
    logic [WIDTH-1:0]            s2_r;
    logic [WIDTH-1:0]            sw_r;
    logic [WIDTH-1:0]            edge_r;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_r;

    logic [WIDTH-1:0]            sw_nxt_s;
    logic [WIDTH-1:0]            edge_nxt_s;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt_s;

    // Per-bit stability counter: any cycle of agreement restarts the count.
    always_comb begin
        sw_nxt_s   = sw_r;
        edge_nxt_s = '0;
        cnt_nxt_s  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2_r[i] == sw_r[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (cnt_r[i] == CNT_MAX) begin
                sw_nxt_s[i]   = s2_r[i];
                edge_nxt_s[i] = 1'b1;
                cnt_nxt_s[i]  = '0;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Synchroniser, counters and debounced outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r   <= '0;
            s2_r   <= '0;
            sw_r   <= '0;
            edge_r <= '0;
            cnt_r  <= '0;
        end else begin
            s1_r   <= sw_i;
            s2_r   <= s1_r;
            sw_r   <= sw_nxt_s;
            edge_r <= edge_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    assign sw_o   = sw_r;
    assign edge_o = edge_r;

`ifdef SW_COND_STICKY_EN
    logic [WIDTH-1:0] chg_r;
    logic             irq_r;

    // Sticky flags: a new edge beats a simultaneous clear; irq lags the flags by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_r <= '0;
            irq_r <= 1'b0;
        end else begin
            chg_r <= (chg_r & ~clr_i) | edge_r;
            irq_r <= |chg_r;
        end
    end

    assign chg_o = chg_r;
    assign irq_o = irq_r;
`else
    logic unused_clr;

    assign unused_clr = ^clr_i;
    assign chg_o      = '0;
    assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_sw_cond.sv
// Directed bench for sw_cond with DEBOUNCE_CYCLES=8, WIDTH=10; sticky checks follow SW_COND_STICKY_EN.
module tb_sw_cond;

`ifdef SW_COND_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sw_i;
    logic [9:0] sw_o;
    logic [9:0] edge_o;
    logic [9:0] clr_i;
    logic [9:0] chg_o;
    logic       irq_o;

    int checks   = 0;
    int failures = 0;

    logic [9:0] acc_sw;
    logic [9:0] acc_edge;

    sw_cond #(.WIDTH(10), .DEBOUNCE_CYCLES(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_i   (sw_i),
        .sw_o   (sw_o),
        .edge_o (edge_o),
        .clr_i  (clr_i),
        .chg_o  (chg_o),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        clr_i = 10'h3FF;
        tick(1);
        clr_i = 10'h000;
        tick(2);
    endtask

    initial begin
        rst   = 1'b1;
        sw_i  = 10'h3FF;
        clr_i = 10'h000;

        // 1. reset, then power-on change
        tick(3);
        chk("rst_sw", 32'(sw_o), 32'h000);
        chk("rst_edge", 32'(edge_o), 32'h000);
        chk("rst_chg", 32'(chg_o), 32'h000);
        chk("rst_irq", 32'(irq_o), 32'h0);
        rst = 1'b0;
        tick(9);
        chk("por_sw_early", 32'(sw_o), 32'h000);
        tick(1);
        chk("por_sw", 32'(sw_o), 32'h3FF);
        chk("por_edge", 32'(edge_o), 32'h3FF);
        tick(1);
        chk("por_edge_off", 32'(edge_o), 32'h000);
        chk("por_chg", 32'(chg_o), STICKY ? 32'h3FF : 32'h000);
        tick(1);
        chk("por_irq", 32'(irq_o), STICKY ? 32'h1 : 32'h0);

        // return everything to 0 and clear flags
        sw_i = 10'h000;
        tick(12);
        chk("all_low", 32'(sw_o), 32'h000);
        clear_all();
        chk("clr_chg", 32'(chg_o), 32'h000);
        chk("clr_irq", 32'(irq_o), 32'h0);

        // 2. clean step on bit 0
        sw_i = 10'h001;
        tick(9);
        chk("step_early", 32'(sw_o), 32'h000);
        chk("step_edge_early", 32'(edge_o), 32'h000);
        tick(1);
        chk("step_sw", 32'(sw_o), 32'h001);
        chk("step_edge", 32'(edge_o), 32'h001);
        tick(1);
        chk("step_edge_off", 32'(edge_o), 32'h000);
        chk("step_hold", 32'(sw_o), 32'h001);

        // 3. glitch of 7 cycles on bit 3 is rejected
        acc_sw   = 10'h000;
        acc_edge = 10'h000;
        sw_i = 10'h009;
        for (int k = 0; k < 7; k++) begin
            tick(1);
            acc_sw   = acc_sw | sw_o;
            acc_edge = acc_edge | edge_o;
        end
        sw_i = 10'h001;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            acc_sw   = acc_sw | sw_o;
            acc_edge = acc_edge | edge_o;
        end
        chk("glitch7_sw", 32'(acc_sw), 32'h001);
        chk("glitch7_edge", 32'(acc_edge), 32'h000);

        // 8-cycle pulse is accepted
        sw_i = 10'h009;
        tick(8);
        sw_i = 10'h001;
        tick(1);
        chk("pulse8_early", 32'(sw_o), 32'h001);
        tick(1);
        chk("pulse8_sw", 32'(sw_o), 32'h009);
        chk("pulse8_edge", 32'(edge_o), 32'h008);
        tick(12);
        chk("pulse8_back", 32'(sw_o), 32'h001);

        // 4. bit 5 bounces every 4 cycles, then holds high
        acc_sw   = 10'h000;
        acc_edge = 10'h000;
        for (int k = 0; k < 24; k++) begin
            sw_i = (k % 2 == 0) ? 10'h021 : 10'h001;
            for (int j = 0; j < 4; j++) begin
                tick(1);
                acc_sw   = acc_sw | sw_o;
                acc_edge = acc_edge | edge_o;
            end
        end
        chk("bounce_sw", 32'(acc_sw), 32'h001);
        chk("bounce_edge", 32'(acc_edge), 32'h000);
        sw_i = 10'h021;
        tick(9);
        chk("bounce_settle_early", 32'(sw_o), 32'h001);
        tick(1);
        chk("bounce_settle", 32'(sw_o), 32'h021);
        chk("bounce_edge5", 32'(edge_o), 32'h020);

        // 5. sticky flags on bit 2
        tick(1);
        clear_all();
        chk("s_pre_chg", 32'(chg_o), 32'h000);
        chk("s_pre_irq", 32'(irq_o), 32'h0);
        sw_i = 10'h025;
        tick(10);
        chk("s_edge", 32'(edge_o), 32'h004);
        tick(1);
        chk("s_chg", 32'(chg_o), STICKY ? 32'h004 : 32'h000);
        tick(1);
        chk("s_irq", 32'(irq_o), STICKY ? 32'h1 : 32'h0);
        chk("s_chg_hold", 32'(chg_o), STICKY ? 32'h004 : 32'h000);
        clr_i = 10'h004;
        tick(1);
        clr_i = 10'h000;
        chk("s_clr_chg", 32'(chg_o), 32'h000);
        tick(1);
        chk("s_clr_irq", 32'(irq_o), 32'h0);
        sw_i = 10'h021;
        tick(10);
        chk("s_edge2", 32'(edge_o), 32'h004);
        clr_i = 10'h004;
        tick(1);
        clr_i = 10'h000;
        chk("s_set_wins", 32'(chg_o), STICKY ? 32'h004 : 32'h000);
        chk("s_sw_after", 32'(sw_o), 32'h021);

        // 6. reset mid-count on bit 7
        sw_i = 10'h0A1;
        tick(5);
        chk("mid_sw_pre", 32'(sw_o), 32'h021);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_sw", 32'(sw_o), 32'h000);
        chk("mid_rst_chg", 32'(chg_o), 32'h000);
        chk("mid_rst_irq", 32'(irq_o), 32'h0);
        tick(9);
        chk("mid_early", 32'(sw_o), 32'h000);
        chk("mid_edge_early", 32'(edge_o), 32'h000);
        tick(1);
        chk("mid_sw", 32'(sw_o), 32'h0A1);
        chk("mid_edge", 32'(edge_o), 32'h0A1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
